// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
// Optional signed-overflow output is controlled by SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT,
    ST_DONE  = DONE
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a_in, b_in, cin_in, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a_in, b_in, cin_in, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a_in, b_in, cin_in, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a_in, b_in, cin_in, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif

endinterface

// File: rtl/serial_adder_fulladder.sv
// Single-bit full adder cell, reused unchanged by the serial adder.
module fulladder (
  input  logic X1,
  input  logic X2,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = X1 ^ X2 ^ Cin;
  assign Cout = (X1 & X2) | (Cin & (X1 ^ X2));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, through a single fulladder.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic               w_in_ready;
  logic               w_out_valid;

  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum_sh;
  logic [WIDTH-1:0]   r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_cout;
  logic               w_s;
  logic               w_cout;
  logic               w_last;

  fulladder u_fa (
    .X1   (r_a_sh[0]),
    .X2   (r_b_sh[0]),
    .Cin  (r_carry),
    .S    (w_s),
    .Cout (w_cout)
  );

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: operands shift out LSB first, sum bits enter from the MSB end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a_sh   <= bus.a_in;
            r_b_sh   <= bus.b_in;
            r_carry  <= bus.cin_in;
            r_cnt    <= '0;
            r_sum_sh <= '0;
          end
        end
        ST_SHIFT: begin
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
          r_carry  <= w_cout;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum  <= {w_s, r_sum_sh[WIDTH-1:1]};
            r_cout <= w_cout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // On the last bit r_carry is the carry into the MSB, w_cout the carry out of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_ovf <= 1'b0;
    else if (r_state == ST_SHIFT && w_last) r_ovf <= r_carry ^ w_cout;
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized regression
// against an arithmetic reference; ovf is checked when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errs = 0;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_state_check(input string tag);
    check({tag, "_rdy"},  64'(bus.in_ready),  64'd1);
    check({tag, "_vld"},  64'(bus.out_valid), 64'd0);
    check({tag, "_sum"},  64'(bus.sum),       64'd0);
    check({tag, "_cout"}, 64'(bus.cout),      64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"},  64'(bus.ovf),       64'd0);
`endif
  endtask

  // One full transaction: accept, wait for the result, hold for `stall` cycles, release.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int stall);
    logic [W:0] full;
    logic       exp_ovf;
    int         lat;
    full    = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    exp_ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);

    @(negedge clk);
    check("idle_rdy", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.cin_in    = c;
    bus.out_ready = 1'b0;
    @(negedge clk);

    lat = 0;
    while (!bus.out_valid && lat < 4*W) begin
      check("busy_rdy", 64'(bus.in_ready), 64'd0);
      bus.in_valid  = 1'($urandom);
      bus.a_in      = W'($urandom);
      bus.b_in      = W'($urandom);
      bus.cin_in    = 1'($urandom);
      bus.out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    bus.out_ready = 1'b0;
    check("latency",  64'(lat),          64'(W));
    check("sum",      64'(bus.sum),      64'(full[W-1:0]));
    check("cout",     64'(bus.cout),     64'(full[W]));
    check("done_rdy", 64'(bus.in_ready), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf",      64'(bus.ovf),      64'(exp_ovf));
`endif

    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'($urandom);
      bus.a_in     = W'($urandom);
      bus.b_in     = W'($urandom);
      @(negedge clk);
      check("hold_vld",  64'(bus.out_valid), 64'd1);
      check("hold_sum",  64'(bus.sum),       64'(full[W-1:0]));
      check("hold_cout", 64'(bus.cout),      64'(full[W]));
      check("hold_rdy",  64'(bus.in_ready),  64'd0);
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("rel_vld",  64'(bus.out_valid), 64'd0);
    check("rel_rdy",  64'(bus.in_ready),  64'd1);
    check("keep_sum", 64'(bus.sum),       64'(full[W-1:0]));
    check("keep_cout", 64'(bus.cout),     64'(full[W]));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.cin_in    = 1'b0;
    bus.out_ready = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_state_check("por");
    rst_n = 1'b1;
    @(negedge clk);
    reset_state_check("idle");

    run_op(8'h35, 8'h4A, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b1, 1);
    run_op(8'h7F, 8'h01, 1'b0, 2);
    run_op(8'h80, 8'h80, 1'b0, 0);
    run_op(8'h12, 8'h34, 1'b1, 5);

    // Abort an addition partway through SHIFT
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_in     = 8'hAA;
    bus.b_in     = 8'h55;
    bus.cin_in   = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    reset_state_check("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      check("no_partial", 64'(bus.out_valid), 64'd0);
    end
    run_op(8'h10, 8'h20, 1'b0, 0);

    for (int n = 0; n < 1000; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial multi-bit adder built around the team's existing single-bit `fulladder` cell. It consumes one operand bit per clock, LSB first, and feeds each bit through `fulladder`. The carry is held in a flip-flop and fed back as Cin for the next bit. It sits directly downstream of `fulladder` as its sequential consumer, and provides a valid/ready wrapper for area-minimal addition.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands a_in/b_in/cin_in are valid.
in_ready  output  1  block can accept operands (high only in IDLE).
a_in  input  WIDTH  operand A.
b_in  input  WIDTH  operand B.
cin_in  input  1  carry-in for bit 0.
out_valid  output  1  result on sum/cout is valid.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  A+B+cin, low WIDTH bits.
cout  output  1  final carry-out.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0.
  - sum=0, cout=0, bit counter=0, carry reg=0, shift regs=0.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: in_ready=1. On in_valid&in_ready, load a_sh<=a_in, b_sh<=b_in, carry<=cin_in, cnt<=0, sum_sh<=0; go to SHIFT.
  - SHIFT: in_ready=0. Each cycle:
    - fulladder X1=a_sh[0], X2=b_sh[0], Cin=carry.
    - a_sh and b_sh shift right by one.
    - sum_sh<={S, sum_sh[WIDTH-1:1]}; carry<=Cout; cnt<=cnt+1.
    - When cnt==WIDTH-1, latch sum<=final sum_sh value (including this cycle's S) and cout<=Cout, then go to DONE.
  - DONE: out_valid=1; sum/cout held stable. On out_ready go to IDLE. out_valid drops the following cycle; in_ready rises the same cycle.
- Latency: out_valid asserts exactly WIDTH cycles after the accepting edge.
- Throughput: one result per WIDTH+2 cycles minimum. There is no IDLE bypass.
- in_valid while not in IDLE is ignored; the operands are not captured.
- out_ready while not in DONE is ignored.
- sum/cout keep the last result after the handshake until the next completion overwrites them.
- Counter width is $clog2(WIDTH). Addition is unsigned modulo 2^WIDTH; the carry goes to cout.
- Reset asserted mid-SHIFT or in DONE aborts the operation immediately and gives the full reset state. No partial result is emitted.
- Operands a_in/b_in may change after acceptance without affecting the result.

Optional Feature:
Macro SERIAL_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit), the signed two's-complement overflow flag.
  - Computed on the final SHIFT cycle as ovf<=carry^Cout, i.e. carry into MSB XOR carry out of MSB.
  - Valid with out_valid and held like sum.
  - Reset value 0.
- Undefined: the ovf port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package/include `serial_adder_pkg`:
  - state encoding localparams: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - default WIDTH constant.
- One sub-module: the existing `fulladder` (ports X1, X2, Cin, S, Cout), instantiated once, unmodified.
- No other sub-modules.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> in_ready=1, out_valid=0, sum=0, cout=0.
- WIDTH=8, a=8'h35, b=8'h4A, cin=0 -> after 8 cycles out_valid=1, sum=8'h7F, cout=0.
- a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1. With SERIAL_ADDER_OVF_EN: ovf=0. Then a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, ovf=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> sum/cout stable, in_ready=0. Toggle in_valid with new operands meanwhile -> ignored. out_ready=1 -> IDLE next cycle.
- Reset mid-SHIFT at cycle 4 of a=8'hAA+b=8'h55 -> all outputs reset. A subsequent 8'h10+8'h20 completes with sum=8'h30.
- Random regression: 1000 operand sets compared against a+b+cin with random out_ready stalls. Verify per-result latency=WIDTH from accept.
